// File: rtl/perif_pkg.sv
// Shared types and constants for the peripheral request arbiter.
package perif_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;

    // Width of a requester index; never narrower than one bit.
    function automatic int gid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perif_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after rr_ptr.
module rr_pick
    import perif_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int GW = gid_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      rr_ptr,
    output logic               any_valid,
    output logic [GW-1:0]      winner
);

    int   pos;
    logic found;

    // Scan upward from rr_ptr with wrap; the first set bit wins.
    always_comb begin
        any_valid = |req;
        winner    = '0;
        found     = 1'b0;
        pos       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req[GW'(pos)]) begin
                winner = GW'(pos);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/perif_req_arbiter.sv
// Round-robin arbiter sharing one send/ack (4-phase) peripheral between
// NUM_REQ requesters. Optional handshake watchdog: define PERIF_ARB_TIMEOUT_EN.
module perif_req_arbiter
    import perif_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int GW = gid_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        err,
    output logic                      busy,
    output logic [GW-1:0]             grant_id,
    output logic                      send,
    output logic [DATA_W-1:0]         data_out,
    input  logic                      ack
);

    arb_state_t          state;
    logic [GW-1:0]       rr_ptr;
    logic                any_valid;
    logic [GW-1:0]       winner;
    logic [DATA_W-1:0]   win_data;
    logic [GW-1:0]       ptr_after;
    logic [NUM_REQ-1:0]  grant_oh;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .any_valid (any_valid),
        .winner    (winner)
    );

    // Select the winner's data slice with constant-index slices only.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == GW'(i)) win_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Pointer moves one past the requester just served, wrapping at NUM_REQ.
    always_comb begin
        ptr_after = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);
    end

    assign grant_oh = NUM_REQ'(1) << grant_id;
    assign busy     = (state != IDLE);

`ifdef PERIF_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;
    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign err        = '0;
`endif

    // Arbitration FSM: grant, drive send until ack, wait for ack release, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            send     <= 1'b0;
            done     <= '0;
            grant_id <= '0;
            data_out <= '0;
            rr_ptr   <= '0;
`ifdef PERIF_ARB_TIMEOUT_EN
            err      <= '0;
            tmo_cnt  <= '0;
`endif
        end else begin
            done <= '0;
`ifdef PERIF_ARB_TIMEOUT_EN
            err  <= '0;
`endif
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_id <= winner;
                        data_out <= win_data;
                        send     <= 1'b1;
                        state    <= SEND;
`ifdef PERIF_ARB_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end
                end
                SEND: begin
                    if (ack) begin
                        send  <= 1'b0;
                        state <= RELEASE;
`ifdef PERIF_ARB_TIMEOUT_EN
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        send   <= 1'b0;
                        err    <= grant_oh;
                        rr_ptr <= ptr_after;
                        state  <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
`endif
                    end
                end
                RELEASE: begin
                    if (!ack) begin
                        done   <= grant_oh;
                        rr_ptr <= ptr_after;
                        state  <= IDLE;
`ifdef PERIF_ARB_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        err    <= grant_oh;
                        rr_ptr <= ptr_after;
                        state  <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
`endif
                    end
                end
                default: begin
                    send  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perif_req_arbiter.sv
// Self-checking bench for perif_req_arbiter: directed scenarios plus
// randomized requesters and peripheral against a behavioural model.
module tb_perif_req_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int T  = 16;
`ifdef PERIF_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            ack = 1'b0;
    logic [N-1:0]    done;
    logic [N-1:0]    err;
    logic            busy;
    logic [1:0]      grant_id;
    logic            send;
    logic [DW-1:0]   data_out;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: phase 0 idle, 1 waiting for ack, 2 waiting for ack release.
    int            m_ph = 0;
    int            m_ptr = 0;
    int            m_gid = 0;
    int            m_cnt = 0;
    logic [DW-1:0] m_data = '0;
    logic [N-1:0]  m_done = '0;
    logic [N-1:0]  m_err = '0;

    perif_req_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(T)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .grant_id (grant_id),
        .send     (send),
        .data_out (data_out),
        .ack      (ack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner = pending requester with the smallest forward distance from the pointer.
    function automatic int pick(input logic [N-1:0] r, input int p);
        int best = -1;
        int bd   = N;
        int d;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                d = (i - p + N) % N;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic abort_txn();
        m_err = N'(1) << m_gid;
        m_ptr = (m_gid + 1) % N;
        m_ph  = 0;
    endtask

    task automatic model_update();
        int w;
        m_done = '0;
        m_err  = '0;
        if (rst) begin
            m_ph = 0; m_ptr = 0; m_gid = 0; m_data = '0; m_cnt = 0;
        end else if (m_ph == 0) begin
            if (req != '0) begin
                w      = pick(req, m_ptr);
                m_gid  = w;
                m_data = req_data[w*DW +: DW];
                m_ph   = 1;
                m_cnt  = 0;
            end
        end else if (m_ph == 1) begin
            if (ack) begin
                m_ph = 2; m_cnt = 0;
            end else if (TMO && m_cnt == T - 1) abort_txn();
            else m_cnt++;
        end else begin
            if (!ack) begin
                m_done = N'(1) << m_gid;
                m_ptr  = (m_gid + 1) % N;
                m_ph   = 0;
            end else if (TMO && m_cnt == T - 1) abort_txn();
            else m_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("send", send, (m_ph == 1));
        chk("busy", busy, (m_ph != 0));
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("grant_id", grant_id, m_gid);
        chk("data_out", data_out, m_data);
    endtask

    // Random requesters (drop on done/err) and a 4-phase peripheral with random latency.
    task automatic run_auto(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (done[i] || err[i]) req[i] = 1'b0;
                else if (req[i]) begin
                    if ($urandom % 16 == 0) req[i] = 1'b0;
                end else if ($urandom % 3 == 0) begin
                    req[i] = 1'b1;
                    req_data[i*DW +: DW] = DW'($urandom);
                end
            end
            if (send) ack = ack | ($urandom % 2 == 1);
            else      ack = ack & ($urandom % 2 == 1);
        end
    endtask

    task automatic wait_send(input string tag, output int g);
        int k = 0;
        while (!send && k < 10) begin
            step();
            k++;
        end
        chk(tag, send, 1);
        g = int'(grant_id);
    endtask

    task automatic do_txn(output int g);
        wait_send("txn_send", g);
        ack = 1'b1; step();
        ack = 1'b0; step();
        chk("txn_done", done, N'(1) << g);
    endtask

    int g;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        // Reset held with all requests high.
        rst = 1'b1; req = 4'b1111; ack = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
        step();
        chk("rst_send", send, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        step();
        chk("rst_send2", send, 0); chk("rst_busy2", busy, 0); chk("rst_gid", grant_id, 0);
        rst = 1'b0; step();
        chk("first_grant", grant_id, 0); chk("first_send", send, 1);
        req = '0;
        ack = 1'b1; step();
        ack = 1'b0; step();
        chk("first_done", done, 4'b0001);
        step();

        // Single request with known data, ack two cycles after send.
        req = 4'b0100; req_data[2*DW +: DW] = 8'hA5;
        step();
        chk("a5_send", send, 1); chk("a5_gid", grant_id, 2); chk("a5_data", data_out, 8'hA5);
        step();
        ack = 1'b1; step();
        chk("a5_send_fall", send, 0);
        ack = 1'b0; step();
        chk("a5_done", done, 4'b0100);
        req = '0; step();
        chk("a5_done_pulse", done, 0);

        // Round-robin order with all requesters busy.
        rst = 1'b1; step();
        rst = 1'b0; req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            do_txn(g);
            chk("rr_order", g, exp_order[t]);
            req[g] = 1'b0; step();
            chk("rr_done_pulse", done, 0);
            req[g] = 1'b1;
        end
        req = '0;
        ack = 1'b1; step();
        ack = 1'b0; step();
        step();

        // Ack already high when the grant happens.
        ack = 1'b1; step();
        req = 4'b0001; step();
        chk("pre_send", send, 1);
        step();
        chk("pre_send_len", send, 0);
        step(); step();
        chk("pre_wait_done", done, 0); chk("pre_wait_busy", busy, 1);
        ack = 1'b0; step();
        chk("pre_done", done, 4'b0001);
        req = '0; step();

        // Reset one cycle into SEND.
        req = 4'b0010; step();
        chk("mid_send", send, 1);
        rst = 1'b1; step();
        chk("mid_rst_send", send, 0); chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
        rst = 1'b0; req = 4'b1111; step();
        chk("mid_rst_ptr", grant_id, 0);
        req = '0;
        ack = 1'b1; step();
        ack = 1'b0; step();
        step();

`ifdef PERIF_ARB_TIMEOUT_EN
        // Watchdog: ack never arrives.
        rst = 1'b1; step();
        rst = 1'b0; req = 4'b0110; ack = 1'b0; step();
        chk("tmo_first", grant_id, 1);
        for (int k = 1; k < T; k++) begin
            step();
            chk("tmo_hold", send, 1);
        end
        step();
        chk("tmo_send_fall", send, 0); chk("tmo_err", err, 4'b0010); chk("tmo_nodone", done, 0);
        req = 4'b0100; step();
        chk("tmo_next", grant_id, 2);
        req = '0;
        ack = 1'b1; step();
        ack = 1'b0; step();
        step();
`endif

        // Randomized traffic.
        rst = 1'b1; step();
        rst = 1'b0;
        run_auto(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
